// File: rtl/quad_encoder_emulator_if.sv
// Quadrature encoder emulator bus.
// The emulator is the master; the motor-controller side is the slave.
interface quad_encoder_emulator_if #(
  parameter int PERIOD_W = 16,
  parameter int POS_W    = 32
);
  logic                       en;
  logic                       dir;
  logic [PERIOD_W-1:0]        period;
  logic                       enc_a;
  logic                       enc_b;
  logic                       enc_z;
  logic                       step_stb;
  logic signed [POS_W-1:0]    pos_count;

  modport master (
    input  en,
    input  dir,
    input  period,
    output enc_a,
    output enc_b,
    output enc_z,
    output step_stb,
    output pos_count
  );

  modport slave (
    output en,
    output dir,
    output period,
    input  enc_a,
    input  enc_b,
    input  enc_z,
    input  step_stb,
    input  pos_count
  );
endinterface

// File: rtl/quad_encoder_emulator.sv
// Quadrature A/B/Z generator at a commanded quarter-step period and direction.
// Period and direction are latched per step so a running step is never truncated.
module quad_encoder_emulator #(
  parameter int PERIOD_W = 16,
  parameter int POS_W    = 32,
  parameter int PPR      = 64
) (
  input  logic                     CLK100MHZ,
  input  logic                     CPU_RESETN,
  quad_encoder_emulator_if.master  bus
);

  localparam int STEPS = 4 * PPR;
  localparam int REV_W = $clog2(STEPS);
  localparam logic [REV_W-1:0] REV_MAX = REV_W'(STEPS - 1);

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } phase_t;

  phase_t                  phase;
  phase_t                  phase_nx;
  logic [PERIOD_W-1:0]     timer;
  logic [PERIOD_W-1:0]     period_act;
  logic                    dir_act;
  logic [REV_W-1:0]        rev_pos;
  logic [REV_W-1:0]        rev_nx;
  logic                    running;
  logic                    step_ev;
  logic                    a_nx;
  logic                    b_nx;
  logic                    enc_a_q;
  logic                    enc_b_q;
  logic                    enc_z_q;
  logic                    stb_q;
  logic signed [POS_W-1:0] pos_q;

  assign running = bus.en && (period_act != '0);
  assign step_ev = running &&
                   (timer == period_act - PERIOD_W'(1));

  always_comb begin
    phase_nx = dir_act ? phase_t'(phase + 2'd1)
                       : phase_t'(phase - 2'd1);
    rev_nx = rev_pos;
    if (dir_act)
      rev_nx = (rev_pos == REV_MAX) ? '0
                                    : rev_pos + REV_W'(1);
    else
      rev_nx = (rev_pos == '0) ? REV_MAX
                               : rev_pos - REV_W'(1);
  end

  // Gray sequence: S0=00 S1=10 S2=11 S3=01
  always_comb begin
    a_nx = 1'b0;
    b_nx = 1'b0;
    unique case (1'b1)
      (phase_nx == S0): begin a_nx = 1'b0; b_nx = 1'b0; end
      (phase_nx == S1): begin a_nx = 1'b1; b_nx = 1'b0; end
      (phase_nx == S2): begin a_nx = 1'b1; b_nx = 1'b1; end
      (phase_nx == S3): begin a_nx = 1'b0; b_nx = 1'b1; end
      default:          begin a_nx = 1'b0; b_nx = 1'b0; end
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      phase      <= S0;
      timer      <= '0;
      period_act <= '0;
      dir_act    <= 1'b1;
      rev_pos    <= '0;
      enc_a_q    <= 1'b0;
      enc_b_q    <= 1'b0;
      enc_z_q    <= 1'b0;
      stb_q      <= 1'b0;
      pos_q      <= '0;
    end else begin
      stb_q <= 1'b0;
      if (!running) begin
        timer      <= '0;
        period_act <= bus.period;
        dir_act    <= bus.dir;
      end else if (step_ev) begin
        timer      <= '0;
        phase      <= phase_nx;
        enc_a_q    <= a_nx;
        enc_b_q    <= b_nx;
        enc_z_q    <= (rev_nx == '0);
        rev_pos    <= rev_nx;
        pos_q      <= dir_act ? pos_q + POS_W'(1)
                              : pos_q - POS_W'(1);
        stb_q      <= 1'b1;
        period_act <= bus.period;
        dir_act    <= bus.dir;
      end else begin
        timer <= timer + PERIOD_W'(1);
      end
    end
  end

  assign bus.enc_a     = enc_a_q;
  assign bus.enc_b     = enc_b_q;
  assign bus.enc_z     = enc_z_q;
  assign bus.step_stb  = stb_q;
  assign bus.pos_count = pos_q;

endmodule

// File: tb/tb_quad_encoder_emulator.sv
// Directed bench for quad_encoder_emulator (PPR=2, 8-bit position).
// A small phase/position/index model supplies the expected outputs.
module tb_quad_encoder_emulator;

  localparam int PERIOD_W = 16;
  localparam int POS_W    = 8;
  localparam int PPR      = 2;
  localparam int STEPS    = 4 * PPR;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  int               mph;
  int               mrev;
  logic signed [7:0] mpos;
  logic             mz;

  quad_encoder_emulator_if #(
    .PERIOD_W(PERIOD_W),
    .POS_W   (POS_W)
  ) bus ();

  quad_encoder_emulator #(
    .PERIOD_W(PERIOD_W),
    .POS_W   (POS_W),
    .PPR     (PPR)
  ) dut (
    .CLK100MHZ (clk),
    .CPU_RESETN(rst_n),
    .bus       (bus.master)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic mreset();
    mph  = 0;
    mrev = 0;
    mpos = '0;
    mz   = 1'b0;
  endtask

  task automatic mstep(input bit fwd);
    mph  = fwd ? (mph + 1) % 4 : (mph + 3) % 4;
    mrev = fwd ? (mrev + 1) % STEPS : (mrev + STEPS - 1) % STEPS;
    mpos = fwd ? mpos + 8'sd1 : mpos - 8'sd1;
    mz   = (mrev == 0);
  endtask

  task automatic chk_state(input string tag, input bit stb);
    chk({tag, "_a"},   32'(bus.enc_a),    (mph == 1 || mph == 2) ? 1 : 0);
    chk({tag, "_b"},   32'(bus.enc_b),    (mph >= 2) ? 1 : 0);
    chk({tag, "_z"},   32'(bus.enc_z),    32'(mz));
    chk({tag, "_stb"}, 32'(bus.step_stb), 32'(stb));
    chk({tag, "_pos"}, 32'(bus.pos_count), 32'(mpos));
  endtask

  initial begin
    mreset();
    // reset held with the generator enabled
    bus.en     = 1'b1;
    bus.dir    = 1'b1;
    bus.period = 16'd3;
    rst_n      = 1'b0;
    tick(4);
    chk_state("t1_reset", 1'b0);

    // forward at period 4
    bus.en     = 1'b0;
    bus.period = 16'd4;
    rst_n      = 1'b1;
    tick(1);
    bus.en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick(3);
      chk("t2_gap_stb", 32'(bus.step_stb), 0);
      tick(1);
      mstep(1'b1);
      chk_state("t2_step", 1'b1);
    end
    chk("t2_pos4", 32'(bus.pos_count), 4);

    // reverse at period 2, then a deferred reversal
    bus.en     = 1'b0;
    bus.dir    = 1'b0;
    bus.period = 16'd2;
    tick(1);
    bus.en = 1'b1;
    tick(2);
    mstep(1'b0);
    chk_state("t3_rev1", 1'b1);
    chk("t3_ab_s3", 32'({bus.enc_a, bus.enc_b}), 1);
    bus.dir = 1'b1;
    tick(1);
    chk("t3_gap_stb", 32'(bus.step_stb), 0);
    tick(1);
    mstep(1'b0);
    chk_state("t3_rev2", 1'b1);
    chk("t3_ab_s2", 32'({bus.enc_a, bus.enc_b}), 3);
    tick(2);
    mstep(1'b1);
    chk_state("t3_fwd", 1'b1);
    chk("t3_ab_back", 32'({bus.enc_a, bus.enc_b}), 1);
    chk("t3_pos", 32'(bus.pos_count), 3);

    // period changes are deferred one step
    bus.period = 16'd5;
    tick(2);
    mstep(1'b1);
    chk_state("t4_old_p2", 1'b1);
    bus.period = 16'd2;
    tick(4);
    chk_state("t4_mid_p5", 1'b0);
    tick(1);
    mstep(1'b1);
    chk_state("t4_p5", 1'b1);
    tick(2);
    mstep(1'b1);
    chk_state("t4_p2", 1'b1);
    bus.period = 16'd0;
    tick(2);
    mstep(1'b1);
    chk_state("t4_last", 1'b1);
    tick(5);
    chk_state("t4_stopped", 1'b0);

    // en dropped mid-step discards the partial step
    bus.period = 16'd3;
    tick(2);
    chk_state("t4_partial", 1'b0);
    bus.en = 1'b0;
    tick(3);
    chk_state("t4_disabled", 1'b0);
    bus.en = 1'b1;
    tick(2);
    chk_state("t4_restart_wait", 1'b0);
    tick(1);
    mstep(1'b1);
    chk_state("t4_restart", 1'b1);
    chk("t4_z_hi", 32'(bus.enc_z), 1);
    chk("t4_pos8", 32'(bus.pos_count), 8);

    // index across a full forward rev at period 1
    bus.period = 16'd1;
    tick(3);
    mstep(1'b1);
    chk_state("t5_first", 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick(1);
      mstep(1'b1);
      chk_state("t5_fwd", 1'b1);
    end

    // index in reverse
    bus.en  = 1'b0;
    bus.dir = 1'b0;
    tick(1);
    bus.en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      mstep(1'b0);
      chk_state("t5_rev", 1'b1);
    end

    // 8-bit position wrap from a fresh reset
    bus.dir    = 1'b1;
    bus.period = 16'd1;
    rst_n      = 1'b0;
    tick(1);
    mreset();
    chk_state("t6_rst", 1'b0);
    rst_n = 1'b1;
    tick(1);
    for (int i = 1; i <= 128; i++) begin
      tick(1);
      mstep(1'b1);
      chk_state("t6_run", 1'b1);
      if (i == 127)
        chk("t6_pos127", 32'(bus.pos_count), 127);
      if (i == 128)
        chk("t6_pos_m128", 32'(bus.pos_count), -128);
    end

    // asynchronous reset between clock edges
    tick(3);
    rst_n = 1'b0;
    #2;
    mreset();
    chk_state("t6_async", 1'b0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk_state("t6_idle", 1'b0);
    tick(1);
    mstep(1'b1);
    chk_state("t6_resume", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
